// File: rtl/sound_cue_scheduler_if.sv
// Request/mute inputs and sound-board outputs of the sound cue scheduler.
interface sound_cue_scheduler_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0] req;
    logic               mute;
    logic [5:0]         selection;
    logic               sound_reset;
    logic               busy;
    logic [2:0]         grant_id;
    logic               done;
    logic [NUM_REQ-1:0] pending;

    modport master (
        output req, mute,
        input  selection, sound_reset, busy, grant_id, done, pending
    );

    modport slave (
        input  req, mute,
        output selection, sound_reset, busy, grant_id, done, pending
    );
endinterface

// File: rtl/sound_cue_scheduler.sv
// Shares the sound board between game-event requesters: edge capture, fixed priority, reset/hold/gap sequencing.
// Optional SOUND_CUE_PREEMPT_EN lets a higher-priority request abort a cue in SEL or GAP.
module sound_cue_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned RST_CYCLES  = 4,
    parameter int unsigned HOLD_CYCLES = 15000,
    parameter int unsigned GAP_CYCLES  = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    sound_cue_scheduler_if.slave  bus
);
    localparam int unsigned SEL_W = 6;
    localparam int unsigned ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RST,
        ST_SEL,
        ST_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               srst_q, srst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [NUM_REQ-1:0] edge_c;
    logic [NUM_REQ-1:0] clr_c;
    logic [ID_W-1:0]    winner_c;

    // Lowest set index wins; bit 0 is the highest priority.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_REQ-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (v[i]) idx = ID_W'(i);
        end
        return idx;
    endfunction

    assign edge_c   = bus.req & ~req_q;
    assign winner_c = lowest_idx(pending_q);

`ifdef SOUND_CUE_PREEMPT_EN
    logic [NUM_REQ-1:0] below_mask_c;
    logic               preempt_c;

    always_comb begin
        below_mask_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            below_mask_c[i] = (ID_W'(i) < grant_q);
        end
    end

    assign preempt_c = |(pending_q & below_mask_c);
`endif

    // Next-state, counter and pending bookkeeping; output values follow the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        grant_d   = grant_q;
        done_d    = 1'b0;
        clr_c     = '0;
        pending_d = pending_q;

        if (bus.mute) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            pending_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (|pending_q) begin
                        state_d          = ST_RST;
                        grant_d          = winner_c;
                        clr_c[winner_c]  = 1'b1;
                        cnt_d            = CNT_W'(RST_CYCLES - 1);
                    end
                end
                ST_RST: begin
                    if (cnt_q == '0) begin
                        state_d = ST_SEL;
                        cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SEL: begin
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase

`ifdef SOUND_CUE_PREEMPT_EN
            // Abort the running cue in favour of a higher-priority pending request.
            if ((state_q == ST_SEL || state_q == ST_GAP) && preempt_c) begin
                state_d         = ST_RST;
                grant_d         = winner_c;
                clr_c           = '0;
                clr_c[winner_c] = 1'b1;
                cnt_d           = CNT_W'(RST_CYCLES - 1);
                done_d          = 1'b0;
            end
`endif

            // A fresh edge in the grant cycle wins over the clear.
            pending_d = (pending_q & ~clr_c) | edge_c;
        end

        sel_d  = {SEL_W{1'b1}};
        if (state_d == ST_SEL) sel_d[grant_d] = 1'b0;
        srst_d = (state_d == ST_RST);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            sel_q     <= {SEL_W{1'b1}};
            srst_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= bus.req;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            srst_q    <= srst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.selection   = sel_q;
    assign bus.sound_reset = srst_q;
    assign bus.busy        = busy_q;
    assign bus.grant_id    = grant_q;
    assign bus.done        = done_q;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_sound_cue_scheduler.sv
// Directed bench for sound_cue_scheduler with short phase lengths; honours SOUND_CUE_PREEMPT_EN.
module tb_sound_cue_scheduler;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned RST_C   = 2;
    localparam int unsigned HOLD_C  = 5;
    localparam int unsigned GAP_C   = 3;

    logic PCLK;
    logic PRESERN;
    int   n_assert;
    int   n_fail;

    sound_cue_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    sound_cue_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .RST_CYCLES (RST_C),
        .HOLD_CYCLES(HOLD_C),
        .GAP_CYCLES (GAP_C),
        .CNT_W      (16)
    ) dut (
        .PCLK   (PCLK),
        .PRESERN(PRESERN),
        .bus    (bus.slave)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] sel_for(input int id);
        logic [5:0] s;
        s     = 6'h3F;
        s[id] = 1'b0;
        return s;
    endfunction

    // Walks the remainder of a cue: rst_left RST cycles, sel_left SEL cycles, GAP, then the done cycle.
    task automatic cue_from(input int id, input int rst_left, input int sel_left);
        for (int c = 0; c < rst_left; c++) begin
            step();
            chk("rst_srst", 32'(bus.sound_reset), 32'd1);
            chk("rst_sel", 32'(bus.selection), 32'h3F);
            chk("rst_grant", 32'(bus.grant_id), 32'(id));
            chk("rst_done", 32'(bus.done), 32'd0);
        end
        for (int c = 0; c < sel_left; c++) begin
            step();
            chk("sel_sel", 32'(bus.selection), 32'(sel_for(id)));
            chk("sel_srst", 32'(bus.sound_reset), 32'd0);
            chk("sel_busy", 32'(bus.busy), 32'd1);
        end
        for (int c = 0; c < GAP_C; c++) begin
            step();
            chk("gap_sel", 32'(bus.selection), 32'h3F);
            chk("gap_srst", 32'(bus.sound_reset), 32'd0);
            chk("gap_busy", 32'(bus.busy), 32'd1);
            chk("gap_done", 32'(bus.done), 32'd0);
        end
        step();
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy", 32'(bus.busy), 32'd0);
        chk("done_grant", 32'(bus.grant_id), 32'(id));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        PRESERN  = 1'b0;
        bus.req  = '0;
        bus.mute = 1'b0;
        repeat (2) step();
        chk("reset_sel", 32'(bus.selection), 32'h3F);
        chk("reset_srst", 32'(bus.sound_reset), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_pending", 32'(bus.pending), 32'd0);
        chk("reset_grant", 32'(bus.grant_id), 32'd0);
        PRESERN = 1'b1;
        repeat (2) step();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single pulse on req[2].
        bus.req = 4'b0100;
        step();
        chk("t2_pending", 32'(bus.pending), 32'b0100);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b0000;
        cue_from(2, RST_C, HOLD_C);
        step();
        chk("t2_done_clear", 32'(bus.done), 32'd0);

        // Simultaneous req[3] and req[1]; req[3] held throughout.
        bus.req = 4'b1010;
        step();
        chk("t3_pending", 32'(bus.pending), 32'b1010);
        bus.req = 4'b1000;
        cue_from(1, RST_C, HOLD_C);
        chk("t3_pending_mid", 32'(bus.pending), 32'b1000);
        cue_from(3, RST_C, HOLD_C);
        repeat (3) step();
        chk("t3_held_once_busy", 32'(bus.busy), 32'd0);
        chk("t3_held_once_pend", 32'(bus.pending), 32'd0);
        bus.req = 4'b0000;
        step();

        // req[0] arrives while track 3 is in SEL.
        bus.req = 4'b1000;
        step();
        bus.req = 4'b0000;
        repeat (RST_C + 1) step();
        chk("t4_in_sel", 32'(bus.selection), 32'(sel_for(3)));
        bus.req = 4'b0001;
        step();
        chk("t4_pending", 32'(bus.pending), 32'b0001);
        chk("t4_still_sel", 32'(bus.selection), 32'(sel_for(3)));
        bus.req = 4'b0000;
`ifdef SOUND_CUE_PREEMPT_EN
        cue_from(0, RST_C, HOLD_C);
`else
        cue_from(3, 0, HOLD_C - 2);
        cue_from(0, RST_C, HOLD_C);
`endif
        step();

        // mute during GAP with req[1] pending; edge under mute ignored.
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0000;
        repeat (RST_C + 1) step();
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        repeat (HOLD_C - 2 + 1) step();
        chk("t5_in_gap_sel", 32'(bus.selection), 32'h3F);
        chk("t5_in_gap_busy", 32'(bus.busy), 32'd1);
        chk("t5_pending", 32'(bus.pending), 32'b0010);
        bus.mute = 1'b1;
        bus.req  = 4'b0100;
        step();
        chk("t5_mute_busy", 32'(bus.busy), 32'd0);
        chk("t5_mute_pend", 32'(bus.pending), 32'd0);
        chk("t5_mute_sel", 32'(bus.selection), 32'h3F);
        chk("t5_mute_done", 32'(bus.done), 32'd0);
        step();
        chk("t5_mute2_pend", 32'(bus.pending), 32'd0);
        chk("t5_mute2_done", 32'(bus.done), 32'd0);
        bus.mute = 1'b0;
        step();
        chk("t5_release_pend", 32'(bus.pending), 32'd0);
        chk("t5_release_busy", 32'(bus.busy), 32'd0);
        step();
        chk("t5_no_replay", 32'(bus.busy), 32'd0);
        bus.req = 4'b0000;
        step();

        // req[1] edge lands on the very edge it is granted.
        bus.req = 4'b0001;
        step();
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        chk("t6_pend_pre", 32'(bus.pending), 32'b0010);
        cue_from(0, RST_C - 1, HOLD_C);
        bus.req = 4'b0010;
        step();
        bus.req = 4'b0000;
        chk("t6_grant", 32'(bus.grant_id), 32'd1);
        chk("t6_srst", 32'(bus.sound_reset), 32'd1);
        chk("t6_pend_kept", 32'(bus.pending), 32'b0010);
        cue_from(1, RST_C - 1, HOLD_C);
        cue_from(1, RST_C, HOLD_C);
        step();
        chk("t6_after_busy", 32'(bus.busy), 32'd0);
        chk("t6_after_pend", 32'(bus.pending), 32'd0);

        // Asynchronous reset in the middle of SEL.
        bus.req = 4'b0100;
        step();
        bus.req = 4'b0000;
        repeat (RST_C + 1) step();
        chk("t7_in_sel", 32'(bus.selection), 32'(sel_for(2)));
        #2;
        PRESERN = 1'b0;
        #1;
        chk("t7_async_sel", 32'(bus.selection), 32'h3F);
        chk("t7_async_srst", 32'(bus.sound_reset), 32'd0);
        chk("t7_async_busy", 32'(bus.busy), 32'd0);
        chk("t7_async_grant", 32'(bus.grant_id), 32'd0);
        chk("t7_async_pend", 32'(bus.pending), 32'd0);
        step();
        PRESERN = 1'b1;
        repeat (3) step();
        chk("t7_post_busy", 32'(bus.busy), 32'd0);
        chk("t7_post_sel", 32'(bus.selection), 32'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
